// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RISC-V MEM stage: data-memory handshake, store lane steering, load extract, MEM/WB register.
module mem_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_mem_valid,
    input  logic [31:0] ex_mem_result_alu,
    input  logic [31:0] ex_mem_op2,
    input  logic [4:0]  ex_mem_rd,
    input  logic        ex_mem_wb_reg_file,
    input  logic        ex_mem_mem_read,
    input  logic        ex_mem_mem_write,
    input  logic [2:0]  ex_mem_load_type,
    input  logic [1:0]  ex_mem_store_type,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic [31:0] data_forward_mem,
    output logic        mem_wb_valid,
    output logic [4:0]  mem_wb_rd,
    output logic        mem_wb_reg_file,
    output logic [31:0] mem_wb_data,
    output logic        misaligned
);
    typedef enum logic {IDLE, REQ} state_t;

    state_t      state, state_next;
    logic [1:0]  off;
    logic        is_load, is_store, mem_op, misal, latch;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [2:0]  req_load_type;
    logic [1:0]  req_off;
    logic [4:0]  req_rd;
    logic        req_wb;

    assign off              = ex_mem_result_alu[1:0];
    assign data_forward_mem = ex_mem_result_alu;
    assign dmem_req         = (state == REQ);

    function automatic logic [31:0] extract(input logic [2:0] lt, input logic [1:0] o,
                                            input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{o, 3'b000} +: 8];
        h = o[1] ? w[31:16] : w[15:0];
        case (lt)
            3'b000:  extract = {{24{b[7]}}, b};
            3'b001:  extract = {{16{h[15]}}, h};
            3'b011:  extract = {24'd0, b};
            3'b100:  extract = {16'd0, h};
            default: extract = w;
        endcase
    endfunction

    // A load with a valid type wins if both read and write are flagged.
    always_comb begin
        is_load    = ex_mem_mem_read && (ex_mem_load_type != 3'b111);
        is_store   = !is_load && ex_mem_mem_write && (ex_mem_store_type != 2'b11);
        mem_op     = ex_mem_valid && (is_load || is_store);
        misal      = 1'b0;
        be_next    = 4'b0000;
        wdata_next = ex_mem_op2;
        if (is_load) begin
            case (ex_mem_load_type)
                3'b001, 3'b100: misal = off[0];
                3'b010:         misal = (off != 2'b00);
                default:        misal = 1'b0;
            endcase
        end else if (is_store) begin
            case (ex_mem_store_type)
                2'b00: begin
                    be_next    = 4'b0001 << off;
                    wdata_next = {4{ex_mem_op2[7:0]}};
                end
                2'b01: begin
                    misal      = off[0];
                    be_next    = 4'b0011 << {off[1], 1'b0};
                    wdata_next = {2{ex_mem_op2[15:0]}};
                end
                default: begin
                    misal   = (off != 2'b00);
                    be_next = 4'b1111;
                end
            endcase
        end
        misal = misal && mem_op;
    end

    always_comb begin
        state_next = state;
        mem_stall  = 1'b0;
        latch      = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op && !misal) begin
                    latch      = 1'b1;
                    mem_stall  = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (dmem_ready) state_next = IDLE;
                else            mem_stall  = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            dmem_we       <= 1'b0;
            dmem_addr     <= 32'd0;
            dmem_wdata    <= 32'd0;
            dmem_be       <= 4'b0000;
            req_load_type <= 3'b111;
            req_off       <= 2'b00;
            req_rd        <= 5'd0;
            req_wb        <= 1'b0;
        end else begin
            state <= state_next;
            if (latch) begin
                dmem_we       <= is_store;
                dmem_addr     <= {ex_mem_result_alu[31:2], 2'b00};
                dmem_wdata    <= wdata_next;
                dmem_be       <= be_next;
                req_load_type <= ex_mem_load_type;
                req_off       <= off;
                req_rd        <= ex_mem_rd;
                req_wb        <= ex_mem_wb_reg_file && (ex_mem_rd != 5'd0) && !is_store;
            end
        end
    end

    // A retiring memory op rebuilds its byte address from the request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wb_valid    <= 1'b0;
            mem_wb_rd       <= 5'd0;
            mem_wb_reg_file <= 1'b0;
            mem_wb_data     <= 32'd0;
            misaligned      <= 1'b0;
        end else if (mem_stall) begin
            mem_wb_valid <= 1'b0;
            misaligned   <= 1'b0;
        end else if (state == REQ) begin
            mem_wb_valid    <= 1'b1;
            mem_wb_rd       <= req_rd;
            mem_wb_reg_file <= req_wb;
            mem_wb_data     <= dmem_we ? {dmem_addr[31:2], req_off}
                                       : extract(req_load_type, req_off, dmem_rdata);
            misaligned      <= 1'b0;
        end else begin
            mem_wb_valid    <= ex_mem_valid;
            mem_wb_rd       <= ex_mem_rd;
            mem_wb_reg_file <= ex_mem_valid && ex_mem_wb_reg_file && (ex_mem_rd != 5'd0)
                               && !is_store && !misal;
            mem_wb_data     <= ex_mem_result_alu;
            misaligned      <= misal;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized self-checking bench for mem_stage against an instruction-level model.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_mem_valid;
    logic [31:0] ex_mem_result_alu, ex_mem_op2;
    logic [4:0]  ex_mem_rd;
    logic        ex_mem_wb_reg_file, ex_mem_mem_read, ex_mem_mem_write;
    logic [2:0]  ex_mem_load_type;
    logic [1:0]  ex_mem_store_type;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        mem_stall;
    logic [31:0] data_forward_mem;
    logic        mem_wb_valid, mem_wb_reg_file, misaligned;
    logic [4:0]  mem_wb_rd;
    logic [31:0] mem_wb_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst_n(rst_n),
        .ex_mem_valid(ex_mem_valid), .ex_mem_result_alu(ex_mem_result_alu),
        .ex_mem_op2(ex_mem_op2), .ex_mem_rd(ex_mem_rd),
        .ex_mem_wb_reg_file(ex_mem_wb_reg_file), .ex_mem_mem_read(ex_mem_mem_read),
        .ex_mem_mem_write(ex_mem_mem_write), .ex_mem_load_type(ex_mem_load_type),
        .ex_mem_store_type(ex_mem_store_type),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .mem_stall(mem_stall), .data_forward_mem(data_forward_mem),
        .mem_wb_valid(mem_wb_valid), .mem_wb_rd(mem_wb_rd), .mem_wb_reg_file(mem_wb_reg_file),
        .mem_wb_data(mem_wb_data), .misaligned(misaligned)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: access size in bytes and the loaded value, from the ISA definition.
    function automatic int access_size(input bit ld, input logic [2:0] lt, input logic [1:0] stt);
        if (ld) return (lt == 3'd0 || lt == 3'd3) ? 1 : (lt == 3'd2) ? 4 : 2;
        return (stt == 2'd0) ? 1 : (stt == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] load_value(input logic [2:0] lt, input logic [31:0] addr,
                                               input logic [31:0] word);
        logic [31:0] sh;
        sh = word >> (8 * (addr % 4));
        case (lt)
            3'd0:    return 32'($signed(sh[7:0]));
            3'd1:    return 32'($signed(sh[15:0]));
            3'd3:    return sh & 32'hFF;
            3'd4:    return sh & 32'hFFFF;
            default: return word;
        endcase
    endfunction

    // Presents one instruction at posedge+1, emulates a memory answering after 'delay'
    // extra cycles, holds EX/MEM while stalled, and checks MEM/WB at posedge+1 after retire.
    task automatic run_instr(input bit valid, input logic [31:0] addr, input logic [31:0] op2,
                             input logic [4:0] rd, input bit wb, input bit rd_en, input bit wr_en,
                             input logic [2:0] lt, input logic [1:0] stt, input int delay,
                             input logic [31:0] rdata);
        bit ld, st, memop, mis;
        int sz;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata, exp_data;
        bit          exp_rf;
        ld    = rd_en && lt != 3'd7;
        st    = !ld && wr_en && stt != 2'd3;
        memop = valid && (ld || st);
        sz    = access_size(ld, lt, stt);
        mis   = memop && (addr % sz != 0);
        exp_be    = 4'd0;
        exp_wdata = op2;
        if (st && sz == 1) begin
            exp_be    = 4'(1 << (addr % 4));
            exp_wdata = op2[7:0] * 32'h01010101;
        end else if (st && sz == 2) begin
            exp_be    = 4'(3 << (addr % 4));
            exp_wdata = op2[15:0] * 32'h00010001;
        end else if (st) begin
            exp_be = 4'hF;
        end
        exp_rf   = valid && wb && rd != 0 && !st && !mis;
        exp_data = (memop && ld && !mis) ? load_value(lt, addr, rdata) : addr;

        ex_mem_valid = valid; ex_mem_result_alu = addr; ex_mem_op2 = op2; ex_mem_rd = rd;
        ex_mem_wb_reg_file = wb; ex_mem_mem_read = rd_en; ex_mem_mem_write = wr_en;
        ex_mem_load_type = lt; ex_mem_store_type = stt;
        dmem_ready = 1'($urandom);
        dmem_rdata = $urandom;
        @(negedge clk);
        check("idle_stall", 32'(mem_stall), 32'(memop && !mis));
        check("idle_req", 32'(dmem_req), 0);
        check("fwd", data_forward_mem, addr);
        if (memop && !mis) begin
            for (int k = 0; k <= delay; k++) begin
                @(posedge clk); #1;
                dmem_ready = (k == delay);
                dmem_rdata = (k == delay) ? rdata : $urandom;
                @(negedge clk);
                check("req", 32'(dmem_req), 1);
                check("req_stall", 32'(mem_stall), 32'(k != delay));
                check("dmem_addr", dmem_addr, addr & ~32'd3);
                check("dmem_we", 32'(dmem_we), 32'(st));
                check("dmem_be", 32'(dmem_be), 32'(exp_be));
                if (st) check("dmem_wdata", dmem_wdata, exp_wdata);
                check("bubble", 32'(mem_wb_valid), 0);
            end
        end
        @(posedge clk); #1;
        dmem_ready = 1'b0;
        check("wb_valid", 32'(mem_wb_valid), 32'(valid));
        check("wb_rd", 32'(mem_wb_rd), 32'(rd));
        check("wb_rf", 32'(mem_wb_reg_file), 32'(exp_rf));
        check("wb_data", mem_wb_data, exp_data);
        check("misaligned", 32'(misaligned), 32'(mis));
    endtask

    task automatic check_reset_outputs();
        check("rst_req", 32'(dmem_req), 0);
        check("rst_we", 32'(dmem_we), 0);
        check("rst_be", 32'(dmem_be), 0);
        check("rst_addr", dmem_addr, 0);
        check("rst_wdata", dmem_wdata, 0);
        check("rst_wb_valid", 32'(mem_wb_valid), 0);
        check("rst_wb_rf", 32'(mem_wb_reg_file), 0);
        check("rst_wb_data", mem_wb_data, 0);
        check("rst_wb_rd", 32'(mem_wb_rd), 0);
        check("rst_mis", 32'(misaligned), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        ex_mem_valid = 0; ex_mem_result_alu = 0; ex_mem_op2 = 0; ex_mem_rd = 0;
        ex_mem_wb_reg_file = 0; ex_mem_mem_read = 0; ex_mem_mem_write = 0;
        ex_mem_load_type = 3'd7; ex_mem_store_type = 2'd3;
        dmem_ready = 0; dmem_rdata = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        check("rst_stall", 32'(mem_stall), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_instr(1, 32'h100, 0, 5, 1, 1, 0, 3'd2, 2'd3, 0, 32'hDEADBEEF);
        run_instr(1, 32'h103, 0, 6, 1, 1, 0, 3'd0, 2'd3, 0, 32'h80123456);
        run_instr(1, 32'h103, 0, 7, 1, 1, 0, 3'd3, 2'd3, 1, 32'h80123456);
        run_instr(1, 32'h22, 32'h0000ABCD, 8, 1, 0, 1, 3'd7, 2'd1, 0, 0);
        run_instr(1, 32'h200, 0, 9, 1, 1, 0, 3'd2, 2'd3, 3, 32'h12345678);
        run_instr(1, 32'h102, 0, 10, 1, 1, 0, 3'd2, 2'd3, 0, 0);
        run_instr(1, 32'h40, 32'h11, 11, 1, 0, 0, 3'd7, 2'd3, 0, 0);

        for (int i = 0; i < 300; i++) begin
            logic [2:0] lt;
            int kind;
            lt   = 3'($urandom_range(0, 5));
            if (lt == 3'd5) lt = 3'd7;
            kind = $urandom_range(0, 2);
            run_instr(($urandom % 8) != 0, $urandom, $urandom, 5'($urandom % 4 == 0 ? 0 : $urandom),
                      1'($urandom), kind == 1, kind == 2, lt, 2'($urandom),
                      $urandom_range(0, 3), $urandom);
        end

        // Reset during the second REQ cycle of a slow load.
        ex_mem_valid = 1; ex_mem_result_alu = 32'h300; ex_mem_rd = 3; ex_mem_wb_reg_file = 1;
        ex_mem_mem_read = 1; ex_mem_mem_write = 0; ex_mem_load_type = 3'd2; dmem_ready = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("pre_rst_req", 32'(dmem_req), 1);
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs();
        ex_mem_valid = 0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        check("post_rst_stall", 32'(mem_stall), 0);
        @(posedge clk); #1;
        run_instr(1, 32'h300, 0, 3, 1, 1, 0, 3'd2, 2'd3, 0, 32'hCAFEF00D);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
